// File: rtl/c7bbiu_arb.sv
// c7bbiu_arb: bus-interface arbiter between the IFU and the LSU, feeding one
// memory port with at most one transaction outstanding (IDLE -> REQ -> DATA).
// Build option: define C7B_BIU_RR_EN for round-robin arbitration; when it is
// undefined, the LSU always has priority over the IFU.
module c7bbiu_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ifu_biu_req,
  input  logic [AW-1:0] ifu_biu_addr,
  output logic          biu_ifu_ack,
  output logic          biu_ifu_data_valid,
  input  logic          lsu_biu_req,
  input  logic          lsu_biu_wr,
  input  logic [AW-1:0] lsu_biu_addr,
  input  logic [DW-1:0] lsu_biu_wdata,
  output logic          biu_lsu_ack,
  output logic          biu_lsu_data_valid,
  output logic          biu_mem_req,
  output logic          biu_mem_wr,
  output logic [AW-1:0] biu_mem_addr,
  output logic [DW-1:0] biu_mem_wdata,
  input  logic          mem_biu_ack,
  input  logic          mem_biu_data_valid,
  input  logic [DW-1:0] mem_biu_rdata,
  output logic [DW-1:0] biu_rdata,
  input  logic          exu_biu_except
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;      // 1 = LSU owns the transaction, 0 = IFU
  logic          kill_q, kill_d;        // IFU responses dropped after a flush
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          ifu_elig, lsu_elig, grant, grant_lsu, ifu_fwd_ok;

`ifdef C7B_BIU_RR_EN
  logic          last_ifu_q, last_ifu_d; // 1 = most recent grant went to the IFU
`endif

  // Arbitration: a flushed IFU request cannot win in the cycle of the flush.
  always_comb begin
    ifu_elig  = ifu_biu_req & ~exu_biu_except;
    lsu_elig  = lsu_biu_req;
    grant     = (state_q == IDLE) & (ifu_elig | lsu_elig);
`ifdef C7B_BIU_RR_EN
    grant_lsu = lsu_elig & (~ifu_elig | last_ifu_q);
    last_ifu_d = grant ? ~grant_lsu : last_ifu_q;
`else
    grant_lsu = lsu_elig;
`endif
  end

  // Next-state logic: grant and latch in IDLE, wait for accept, wait for completion.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    kill_d    = kill_q;
    mem_req_d = mem_req_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant) begin
          state_d   = REQ;
          owner_d   = grant_lsu;
          mem_req_d = 1'b1;
          addr_d    = grant_lsu ? lsu_biu_addr : ifu_biu_addr;
          wr_d      = grant_lsu & lsu_biu_wr;
          wdata_d   = lsu_biu_wdata;
        end
      end
      REQ: begin
        if (exu_biu_except && !owner_q) kill_d = 1'b1;
        // An accept wins over a same-cycle completion, which is not ours yet.
        if (mem_biu_ack) begin
          state_d   = DATA;
          mem_req_d = 1'b0;
        end
      end
      DATA: begin
        if (exu_biu_except && !owner_q) kill_d = 1'b1;
        if (mem_biu_data_valid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        kill_d    = 1'b0;
      end
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      kill_q    <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      kill_q    <= kill_d;
      mem_req_q <= mem_req_d;
    end
  end

`ifdef C7B_BIU_RR_EN
  // Round-robin pointer; after reset the IFU counts as the last grantee.
  always_ff @(posedge clk) begin
    if (!resetn) last_ifu_q <= 1'b1;
    else         last_ifu_q <= last_ifu_d;
  end
`endif

  // Request latches; their contents only matter while a transaction is live.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  // Response steering: pulses only to the owner, IFU gated by flush and kill.
  always_comb begin
    ifu_fwd_ok         = ~owner_q & ~kill_q & ~exu_biu_except;
    biu_ifu_ack        = (state_q == REQ)  & mem_biu_ack        & ifu_fwd_ok;
    biu_lsu_ack        = (state_q == REQ)  & mem_biu_ack        & owner_q;
    biu_ifu_data_valid = (state_q == DATA) & mem_biu_data_valid & ifu_fwd_ok;
    biu_lsu_data_valid = (state_q == DATA) & mem_biu_data_valid & owner_q;
    biu_mem_req        = mem_req_q;
    biu_mem_wr         = wr_q;
    biu_mem_addr       = addr_q;
    biu_mem_wdata      = wdata_q;
    biu_rdata          = mem_biu_rdata;
  end

endmodule

// File: tb/tb_c7bbiu_arb.sv
// Testbench for c7bbiu_arb: per-cycle vector table with a scoreboard queue,
// followed by a hand-written flush-during-DATA sequence.
module tb_c7bbiu_arb;

`ifdef C7B_BIU_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  // Owner of the second contested grant: 1 = LSU (fixed), 0 = IFU (round-robin).
  localparam bit W = !RR;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ifu_biu_req;
  logic [31:0] ifu_biu_addr;
  logic        biu_ifu_ack, biu_ifu_data_valid;
  logic        lsu_biu_req, lsu_biu_wr;
  logic [31:0] lsu_biu_addr, lsu_biu_wdata;
  logic        biu_lsu_ack, biu_lsu_data_valid;
  logic        biu_mem_req, biu_mem_wr;
  logic [31:0] biu_mem_addr, biu_mem_wdata;
  logic        mem_biu_ack, mem_biu_data_valid;
  logic [31:0] mem_biu_rdata, biu_rdata;
  logic        exu_biu_except;

  always #5 clk = ~clk;

  c7bbiu_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .ifu_biu_req(ifu_biu_req), .ifu_biu_addr(ifu_biu_addr),
    .biu_ifu_ack(biu_ifu_ack), .biu_ifu_data_valid(biu_ifu_data_valid),
    .lsu_biu_req(lsu_biu_req), .lsu_biu_wr(lsu_biu_wr),
    .lsu_biu_addr(lsu_biu_addr), .lsu_biu_wdata(lsu_biu_wdata),
    .biu_lsu_ack(biu_lsu_ack), .biu_lsu_data_valid(biu_lsu_data_valid),
    .biu_mem_req(biu_mem_req), .biu_mem_wr(biu_mem_wr),
    .biu_mem_addr(biu_mem_addr), .biu_mem_wdata(biu_mem_wdata),
    .mem_biu_ack(mem_biu_ack), .mem_biu_data_valid(mem_biu_data_valid),
    .mem_biu_rdata(mem_biu_rdata), .biu_rdata(biu_rdata),
    .exu_biu_except(exu_biu_except)
  );

  typedef struct {
    string nm;
    bit rstn, ireq, lreq, lwr, mack, mdv, exc;
    bit mreq, own, mwr, iack, idv, lack, ldv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input string nm,
                     input bit rstn, ireq, lreq, lwr, mack, mdv, exc,
                     input bit mreq, own, mwr, iack, idv, lack, ldv);
    vec_t v;
    v.nm = nm; v.rstn = rstn; v.ireq = ireq; v.lreq = lreq; v.lwr = lwr;
    v.mack = mack; v.mdv = mdv; v.exc = exc;
    v.mreq = mreq; v.own = own; v.mwr = mwr;
    v.iack = iack; v.idv = idv; v.lack = lack; v.ldv = ldv;
    tbl.push_back(v);
  endtask

  task automatic check_vec(input vec_t e, input int idx);
    logic [31:0] ea;
    bit bad;
    bad = ({biu_mem_req, biu_ifu_ack, biu_ifu_data_valid, biu_lsu_ack, biu_lsu_data_valid}
           !== {e.mreq, e.iack, e.idv, e.lack, e.ldv});
    ea = e.own ? 32'h0000_2000 : 32'h0000_0100;
    if (e.mreq) begin
      if (biu_mem_addr !== ea || biu_mem_wr !== e.mwr) bad = 1'b1;
      if (e.own && biu_mem_wdata !== 32'h0000_55AA) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s[%0d] got req=%b wr=%b addr=%h wdata=%h iack=%b idv=%b lack=%b ldv=%b; exp req=%b wr=%b addr=%h iack=%b idv=%b lack=%b ldv=%b",
               e.nm, idx, biu_mem_req, biu_mem_wr, biu_mem_addr, biu_mem_wdata,
               biu_ifu_ack, biu_ifu_data_valid, biu_lsu_ack, biu_lsu_data_valid,
               e.mreq, e.mwr, ea, e.iack, e.idv, e.lack, e.ldv);
    end
    checks++;
    if (biu_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rdata[%0d] got %h exp deadbeef", idx, biu_rdata);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    bit   found;
    resetn = 1'b0; ifu_biu_req = 1'b0; lsu_biu_req = 1'b0; lsu_biu_wr = 1'b0;
    ifu_biu_addr = 32'h100; lsu_biu_addr = 32'h2000; lsu_biu_wdata = 32'h55AA;
    mem_biu_ack = 1'b0; mem_biu_data_valid = 1'b0; mem_biu_rdata = 32'hDEAD_BEEF;
    exu_biu_except = 1'b0;

    // name   rstn ireq lreq lwr mack mdv exc | mreq own mwr iack idv lack ldv
    add("rst", 0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("rst", 0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    // Single IFU read: grant, REQ for 3 cycles, accept, completion 3 cycles later.
    add("ifu_rd", 1, 1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("ifu_rd", 1, 1,0,0, 0,0,0, 1,0,0, 0,0,0,0);
    add("ifu_rd", 1, 1,0,0, 0,0,0, 1,0,0, 0,0,0,0);
    add("ifu_rd", 1, 1,0,0, 1,0,0, 1,0,0, 1,0,0,0);
    add("ifu_rd", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("ifu_rd", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("ifu_rd", 1, 0,0,0, 0,1,0, 0,0,0, 0,1,0,0);
    add("ifu_rd", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("rst", 0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    // Contention after reset: LSU first, then the contested second round.
    add("arb", 1, 1,1,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("arb", 1, 1,1,0, 0,0,0, 1,1,0, 0,0,0,0);
    add("arb", 1, 1,1,0, 1,0,0, 1,1,0, 0,0,1,0);
    add("arb", 1, 1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("arb", 1, 1,0,0, 0,1,0, 0,0,0, 0,0,0,1);
    add("arb2", 1, 1,1,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("arb2", 1, 1,1,0, 1,0,0, 1,W,0, !W,0,W,0);
    add("arb2", 1, W,!W,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("arb2", 1, W,!W,0, 0,1,0, 0,0,0, 0,!W,0,W);
    add("arb3", 1, W,!W,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("arb3", 1, W,!W,0, 1,0,0, 1,!W,0, W,0,!W,0);
    add("arb3", 1, 0,0,0, 0,1,0, 0,0,0, 0,W,0,!W);
    add("arb3", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    // LSU write; stray completion in REQ and stray accept in DATA/IDLE ignored.
    add("lsu_wr", 1, 0,1,1, 0,0,0, 0,0,0, 0,0,0,0);
    add("lsu_wr", 1, 0,1,1, 0,1,0, 1,1,1, 0,0,0,0);
    add("lsu_wr", 1, 0,1,1, 0,0,0, 1,1,1, 0,0,0,0);
    add("lsu_wr", 1, 0,1,1, 1,0,0, 1,1,1, 0,0,1,0);
    add("lsu_wr", 1, 0,0,0, 1,0,0, 0,0,0, 0,0,0,0);
    add("lsu_wr", 1, 0,0,0, 0,1,0, 0,0,0, 0,0,0,1);
    add("lsu_wr", 1, 0,0,0, 1,1,0, 0,0,0, 0,0,0,0);
    // Flushed IFU request ineligible; accept+completion together -> accept only.
    add("ackdv", 1, 1,0,0, 0,0,1, 0,0,0, 0,0,0,0);
    add("ackdv", 1, 1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("ackdv", 1, 1,0,0, 0,0,0, 1,0,0, 0,0,0,0);
    add("ackdv", 1, 1,0,0, 1,1,0, 1,0,0, 1,0,0,0);
    add("ackdv", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("ackdv", 1, 0,0,0, 0,1,0, 0,0,0, 0,1,0,0);
    add("ackdv", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    // Flush in REQ kills the IFU transaction; next one is forwarded normally.
    add("kill", 1, 1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("kill", 1, 1,0,0, 0,0,1, 1,0,0, 0,0,0,0);
    add("kill", 1, 1,0,0, 1,0,0, 1,0,0, 0,0,0,0);
    add("kill", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("kill", 1, 0,0,0, 0,1,0, 0,0,0, 0,0,0,0);
    add("kill", 1, 1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("kill", 1, 1,0,0, 1,0,0, 1,0,0, 1,0,0,0);
    add("kill", 1, 0,0,0, 0,1,0, 0,0,0, 0,1,0,0);
    add("kill", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    // Flush in the accept cycle itself suppresses the accept.
    add("samecyc", 1, 1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("samecyc", 1, 1,0,0, 1,0,1, 1,0,0, 0,0,0,0);
    add("samecyc", 1, 0,0,0, 0,1,0, 0,0,0, 0,0,0,0);
    add("samecyc", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    // Flush has no effect on LSU-owned transactions.
    add("lsu_exc", 1, 0,1,0, 0,0,1, 0,0,0, 0,0,0,0);
    add("lsu_exc", 1, 0,1,0, 1,0,1, 1,1,0, 0,0,1,0);
    add("lsu_exc", 1, 0,0,0, 0,1,1, 0,0,0, 0,0,0,1);
    add("lsu_exc", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    // Reset in DATA abandons the transaction; late completion ignored.
    add("rst_data", 1, 1,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("rst_data", 1, 1,0,0, 1,0,0, 1,0,0, 1,0,0,0);
    add("rst_data", 0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    add("rst_data", 1, 0,0,0, 0,1,0, 0,0,0, 0,0,0,0);
    add("rst_data", 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      resetn = tbl[i].rstn; ifu_biu_req = tbl[i].ireq; lsu_biu_req = tbl[i].lreq;
      lsu_biu_wr = tbl[i].lwr; mem_biu_ack = tbl[i].mack;
      mem_biu_data_valid = tbl[i].mdv; exu_biu_except = tbl[i].exc;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      check_vec(e, i);
    end

    // Flush while an IFU read sits in DATA, then a normal IFU read.
    @(posedge clk); #1;
    resetn = 1'b1; lsu_biu_req = 1'b0; mem_biu_ack = 1'b0; mem_biu_data_valid = 1'b0;
    exu_biu_except = 1'b0; mem_biu_rdata = 32'h1234_5678; ifu_biu_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (biu_mem_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("seq_req_wait", {31'd0, found}, 32'd1);
    chk("seq_addr", biu_mem_addr, 32'h100);
    @(posedge clk); #1 mem_biu_ack = 1'b1;
    @(negedge clk); chk("seq_ack", {31'd0, biu_ifu_ack}, 32'd1);
    @(posedge clk); #1 mem_biu_ack = 1'b0; ifu_biu_req = 1'b0; exu_biu_except = 1'b1;
    @(negedge clk); chk("seq_exc_dv", {31'd0, biu_ifu_data_valid}, 32'd0);
    chk("seq_exc_req", {31'd0, biu_mem_req}, 32'd0);
    @(posedge clk); #1 exu_biu_except = 1'b0; mem_biu_data_valid = 1'b1;
    @(negedge clk); chk("seq_killed_dv", {31'd0, biu_ifu_data_valid}, 32'd0);
    @(posedge clk); #1 mem_biu_data_valid = 1'b0; ifu_biu_req = 1'b1;
    @(negedge clk); chk("seq_idle", {31'd0, biu_mem_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("seq_regrant", {31'd0, biu_mem_req}, 32'd1);
    @(posedge clk); #1 mem_biu_ack = 1'b1;
    @(negedge clk); chk("seq_ack2", {31'd0, biu_ifu_ack}, 32'd1);
    @(posedge clk); #1 mem_biu_ack = 1'b0; ifu_biu_req = 1'b0; mem_biu_data_valid = 1'b1;
    @(negedge clk); chk("seq_dv2", {31'd0, biu_ifu_data_valid}, 32'd1);
    chk("seq_rdata", biu_rdata, 32'h1234_5678);
    @(posedge clk); #1 mem_biu_data_valid = 1'b0;
    @(negedge clk); chk("seq_end", {31'd0, biu_ifu_data_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c7bbiu_arb.md
C7BBIU_ARB -- requirements
Module: c7bbiu_arb

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have IFU-side ports:
- ifu_biu_req  in  1  IFU fetch request, held until acked.
- ifu_biu_addr  in  AW  fetch address.
- biu_ifu_ack  out  1  accept pulse.
- biu_ifu_data_valid  out  1  read-data pulse.
REQ-006 SHALL have LSU-side ports:
- lsu_biu_req  in  1  LSU request, held until acked.
- lsu_biu_wr  in  1  1 = write.
- lsu_biu_addr  in  AW  access address.
- lsu_biu_wdata  in  DW  store data.
- biu_lsu_ack  out  1  accept pulse.
- biu_lsu_data_valid  out  1  completion pulse.
REQ-007 SHALL have memory-side ports:
- biu_mem_req  out  1  memory request.
- biu_mem_wr  out  1  write flag.
- biu_mem_addr  out  AW  address.
- biu_mem_wdata  out  DW  store data.
- mem_biu_ack  in  1  accept pulse.
- mem_biu_data_valid  in  1  completion pulse.
- mem_biu_rdata  in  DW  read data.
REQ-008 SHALL have biu_rdata  out  DW  mem_biu_rdata passed through to both requesters, and exu_biu_except  in  1  pipeline flush.

Function
REQ-009 SHALL implement an FSM with states IDLE, REQ and DATA; at most one transaction outstanding.
REQ-010 IDLE: on any eligible request, SHALL latch the winner (owner), addr, wr and wdata, and go to REQ next cycle.
REQ-011 An IFU request SHALL be ineligible in a cycle where exu_biu_except=1.
REQ-012 REQ: biu_mem_req SHALL be 1, driven from a flop, and address/wr/wdata SHALL be held stable from the latches.
REQ-013 REQ: on mem_biu_ack, the FSM SHALL go to DATA next cycle, and biu_<owner>_ack SHALL pulse combinationally in that same cycle.
REQ-014 DATA: on mem_biu_data_valid, biu_<owner>_data_valid SHALL pulse combinationally in that cycle and the FSM SHALL return to IDLE.
REQ-015 Earliest re-grant SHALL be the cycle after return to IDLE; grant-to-biu_mem_req latency is 1 cycle.
REQ-016 mem_biu_ack SHALL be ignored outside REQ; mem_biu_data_valid SHALL be ignored outside DATA.
REQ-017 If mem_biu_ack and mem_biu_data_valid both arrive in REQ in the same cycle, the ack SHALL be honoured and data_valid ignored.
REQ-018 A kill flag SHALL be set if exu_biu_except=1 while owner=IFU in REQ or DATA.
REQ-019 While the kill flag is set, biu_ifu_ack and biu_ifu_data_valid SHALL be suppressed, and the transaction SHALL still complete on the memory side.
REQ-020 The kill flag SHALL clear on return to IDLE.
REQ-021 exu_biu_except SHALL also suppress biu_ifu_ack or biu_ifu_data_valid in the same cycle it rises.
REQ-022 exu_biu_except SHALL have no effect on LSU-owned transactions.
REQ-023 ack and data_valid outputs SHALL be single-cycle pulses and SHALL never be asserted to the non-owner.

Reset
REQ-024 With resetn=0 at a clock edge, the FSM SHALL go to IDLE and biu_mem_req, biu_ifu_ack, biu_lsu_ack, both data_valid outputs, the kill flag and owner SHALL go to 0.
REQ-025 With resetn=0, the round-robin pointer SHALL be set to "last grant = IFU".
REQ-026 Reset mid-transaction SHALL abandon the transaction, and no ack or data_valid SHALL be forwarded afterward.
REQ-027 The address/data latches SHALL NOT require reset.

Configuration
REQ-028 With macro C7B_BIU_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins, and the pointer updates at each grant.
REQ-029 With C7B_BIU_RR_EN undefined, arbitration SHALL be fixed priority, LSU over IFU, and the pointer logic SHALL be absent.

Verification
REQ-030 Single IFU read: ifu req, addr=0x100; mem ack at cycle 3, data_valid with rdata=0xDEADBEEF at cycle 6 -> biu_mem_req cycles 1-3, biu_ifu_ack at 3, biu_ifu_data_valid at 6, biu_rdata=0xDEADBEEF.
REQ-031 Simultaneous IFU and LSU requests after reset -> LSU granted first in both modes; IFU next in RR mode; IFU starves only while LSU keeps requesting in fixed mode.
REQ-032 LSU write: addr=0x2000, wdata=0x55AA -> biu_mem_wr=1, biu_mem_addr=0x2000 and biu_mem_wdata=0x55AA held until ack; biu_lsu_data_valid on completion.
REQ-033 exu_biu_except during IFU DATA state -> no biu_ifu_data_valid; FSM returns to IDLE on mem data_valid; next IFU request granted normally.
REQ-034 Back-to-back mem_biu_ack and mem_biu_data_valid in the same REQ cycle -> ack only; FSM goes to DATA and waits for a later data_valid.
REQ-035 resetn=0 asserted in DATA -> all outputs 0 next cycle; a late mem_biu_data_valid is ignored.
